// File: rtl/rx_frame_checker.sv
// Receive-side frame checker: parses TLP/DLLP symbol streams, verifies CRC-8, delivers payloads
// over ready/valid ports and reports per-TLP ACK/NACK through a small status FIFO.
module rx_frame_checker #(
  parameter int unsigned TLP_WIDTH         = 32,
  parameter int unsigned DLLP_WIDTH        = 16,
  parameter int unsigned TLP_ID_WIDTH      = 3,
  parameter int unsigned STATUS_AW         = 2,
  parameter int unsigned CNT_WIDTH         = 16,
  parameter logic [7:0]  CRC_POLY          = 8'h07,
  parameter logic [7:0]  CRC_INIT          = 8'hFF,
  parameter logic [7:0]  K_CODE_START_TLP  = 8'hFB,
  parameter logic [7:0]  K_CODE_START_DLLP = 8'h5C,
  parameter logic [7:0]  K_CODE_STOP       = 8'hFD,
  parameter logic [7:0]  K_CODE_SKP        = 8'h1C
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic                    i_phys_k_en,
  input  logic [7:0]              i_phys_byte,
  output logic [TLP_WIDTH-1:0]    o_tlp,
  output logic [TLP_ID_WIDTH-1:0] o_tlp_id,
  output logic                    o_tlp_valid,
  input  logic                    i_tlp_rdy,
  output logic [DLLP_WIDTH-1:0]   o_dllp,
  output logic                    o_dllp_valid,
  input  logic                    i_dllp_rdy,
  output logic [TLP_ID_WIDTH:0]   o_status,
  output logic                    o_status_valid,
  input  logic                    i_status_ack,
  input  logic                    i_clr_cnt,
  output logic [CNT_WIDTH-1:0]    o_crc_err_cnt,
  output logic [CNT_WIDTH-1:0]    o_frm_err_cnt,
  output logic [CNT_WIDTH-1:0]    o_ovf_cnt
);

  localparam int unsigned TlpBytes  = TLP_WIDTH / 8;
  localparam int unsigned DllpBytes = DLLP_WIDTH / 8;
  localparam int unsigned ShW       = (TLP_WIDTH > DLLP_WIDTH) ? TLP_WIDTH : DLLP_WIDTH;
  localparam int unsigned Depth     = 1 << STATUS_AW;
  localparam int unsigned StW       = TLP_ID_WIDTH + 1;

  typedef enum logic [2:0] {StIdle, StTlpHdr, StTlpData, StDllpData, StCrc, StStop} state_e;

  state_e                  state_q;
  logic [7:0]              crc_q;
  logic [5:0]              byte_cnt_q;
  logic                    is_tlp_q, crc_ok_q;
  logic [TLP_ID_WIDTH-1:0] id_q;
  logic [ShW-1:0]          shift_q;

  logic [TLP_WIDTH-1:0]    tlp_q;
  logic [TLP_ID_WIDTH-1:0] tlp_id_q;
  logic                    tlp_valid_q, dllp_valid_q;
  logic [DLLP_WIDTH-1:0]   dllp_q;
  logic [StW-1:0]          st_mem_q [Depth];
  logic [STATUS_AW-1:0]    st_wr_q, st_rd_q;
  logic [STATUS_AW:0]      st_cnt_q;
  logic [CNT_WIDTH-1:0]    crc_err_cnt_q, frm_err_cnt_q, ovf_cnt_q;

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ CRC_POLY) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                   input logic ev, input logic clr);
    if (clr) return '0;
    if (ev && (c != '1)) return c + 1'b1;
    return c;
  endfunction

  logic is_skp, is_kc, is_start_tlp, is_start_dllp, in_frame, stop_ok, frm_err;
  logic tlp_good, tlp_load, tlp_drop, dllp_good, dllp_load, dllp_drop, crc_err_ev;
  logic st_push, st_full, st_pop, st_wr, st_drop, ovf_ev;

  always_comb begin
    is_skp        = i_phys_k_en && (i_phys_byte == K_CODE_SKP);
    is_kc         = i_phys_k_en && !is_skp;
    is_start_tlp  = is_kc && (i_phys_byte == K_CODE_START_TLP);
    is_start_dllp = is_kc && (i_phys_byte == K_CODE_START_DLLP);
    in_frame      = state_q inside {StTlpHdr, StTlpData, StDllpData, StCrc};
    stop_ok       = (state_q == StStop) && is_kc && (i_phys_byte == K_CODE_STOP);
    frm_err       = (in_frame && is_kc) || ((state_q == StStop) && !is_skp && !stop_ok);
    tlp_good      = stop_ok && is_tlp_q && crc_ok_q;
    tlp_load      = tlp_good && (!tlp_valid_q || i_tlp_rdy);
    tlp_drop      = tlp_good && !tlp_load;
    dllp_good     = stop_ok && !is_tlp_q && crc_ok_q;
    dllp_load     = dllp_good && (!dllp_valid_q || i_dllp_rdy);
    dllp_drop     = dllp_good && !dllp_load;
    crc_err_ev    = stop_ok && !crc_ok_q;
    st_push       = stop_ok && is_tlp_q;
    st_full       = (st_cnt_q == (STATUS_AW + 1)'(Depth));
    st_pop        = i_status_ack && (st_cnt_q != '0);
    st_wr         = st_push && !st_full;
    st_drop       = st_push && st_full;
    ovf_ev        = tlp_drop || dllp_drop || st_drop;
  end

  // Frame parser; SKP symbols leave every register untouched.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q    <= StIdle;
      crc_q      <= CRC_INIT;
      byte_cnt_q <= '0;
      is_tlp_q   <= 1'b0;
      crc_ok_q   <= 1'b0;
      id_q       <= '0;
      shift_q    <= '0;
    end else if (!is_skp) begin
      if (is_start_tlp && (state_q != StStop)) begin
        state_q  <= StTlpHdr;
        crc_q    <= CRC_INIT;
        is_tlp_q <= 1'b1;
      end else if (is_start_dllp && (state_q != StStop)) begin
        state_q    <= StDllpData;
        crc_q      <= CRC_INIT;
        byte_cnt_q <= 6'(DllpBytes - 1);
        is_tlp_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StTlpHdr: begin
            if (is_kc) state_q <= StIdle;
            else begin
              id_q       <= i_phys_byte[TLP_ID_WIDTH-1:0];
              crc_q      <= crc8_upd(crc_q, i_phys_byte);
              byte_cnt_q <= 6'(TlpBytes - 1);
              state_q    <= StTlpData;
            end
          end
          StTlpData, StDllpData: begin
            if (is_kc) state_q <= StIdle;
            else begin
              shift_q <= ShW'({shift_q, i_phys_byte});
              crc_q   <= crc8_upd(crc_q, i_phys_byte);
              if (byte_cnt_q == '0) state_q <= StCrc;
              else byte_cnt_q <= byte_cnt_q - 1'b1;
            end
          end
          StCrc: begin
            if (is_kc) state_q <= StIdle;
            else begin
              crc_ok_q <= (crc_q == i_phys_byte);
              state_q  <= StStop;
            end
          end
          StStop:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      tlp_q         <= '0;
      tlp_id_q      <= '0;
      tlp_valid_q   <= 1'b0;
      dllp_q        <= '0;
      dllp_valid_q  <= 1'b0;
      st_wr_q       <= '0;
      st_rd_q       <= '0;
      st_cnt_q      <= '0;
      crc_err_cnt_q <= '0;
      frm_err_cnt_q <= '0;
      ovf_cnt_q     <= '0;
      for (int i = 0; i < Depth; i++) st_mem_q[i] <= '0;
    end else begin
      if (tlp_load) begin
        tlp_q       <= shift_q[TLP_WIDTH-1:0];
        tlp_id_q    <= id_q;
        tlp_valid_q <= 1'b1;
      end else if (i_tlp_rdy) begin
        tlp_valid_q <= 1'b0;
      end
      if (dllp_load) begin
        dllp_q       <= shift_q[DLLP_WIDTH-1:0];
        dllp_valid_q <= 1'b1;
      end else if (i_dllp_rdy) begin
        dllp_valid_q <= 1'b0;
      end
      if (st_wr) begin
        st_mem_q[st_wr_q] <= {tlp_load, id_q};
        st_wr_q           <= st_wr_q + 1'b1;
      end
      if (st_pop) st_rd_q <= st_rd_q + 1'b1;
      st_cnt_q      <= st_cnt_q + {{STATUS_AW{1'b0}}, st_wr} - {{STATUS_AW{1'b0}}, st_pop};
      crc_err_cnt_q <= sat_inc(crc_err_cnt_q, crc_err_ev, i_clr_cnt);
      frm_err_cnt_q <= sat_inc(frm_err_cnt_q, frm_err, i_clr_cnt);
      ovf_cnt_q     <= sat_inc(ovf_cnt_q, ovf_ev, i_clr_cnt);
    end
  end

  assign o_tlp          = tlp_q;
  assign o_tlp_id       = tlp_id_q;
  assign o_tlp_valid    = tlp_valid_q;
  assign o_dllp         = dllp_q;
  assign o_dllp_valid   = dllp_valid_q;
  assign o_status       = st_mem_q[st_rd_q];
  assign o_status_valid = (st_cnt_q != '0);
  assign o_crc_err_cnt  = crc_err_cnt_q;
  assign o_frm_err_cnt  = frm_err_cnt_q;
  assign o_ovf_cnt      = ovf_cnt_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed bench for rx_frame_checker: default instance plus a 2-entry status FIFO instance.
module tb_rx_frame_checker;

  localparam logic [7:0] Stp = 8'hFB;
  localparam logic [7:0] Sdp = 8'h5C;
  localparam logic [7:0] Stop = 8'hFD;
  localparam logic [7:0] Skp = 8'h1C;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        k_en = 1'b0;
  logic [7:0]  phys_byte = 8'h00;
  logic        tlp_rdy = 1'b0, dllp_rdy = 1'b0, st_ack = 1'b0, clr = 1'b0;

  logic [31:0] tlp;
  logic [2:0]  tlp_id;
  logic        tlp_valid;
  logic [15:0] dllp;
  logic        dllp_valid;
  logic [3:0]  status;
  logic        status_valid;
  logic [15:0] crc_cnt, frm_cnt, ovf_cnt;

  logic [31:0] tlp1;
  logic [2:0]  tlp_id1;
  logic        tlp_valid1;
  logic [15:0] dllp1;
  logic        dllp_valid1;
  logic [3:0]  status1;
  logic        status_valid1;
  logic [15:0] crc_cnt1, frm_cnt1, ovf_cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rx_frame_checker dut (
    .i_clk(clk), .i_arst(arst), .i_phys_k_en(k_en), .i_phys_byte(phys_byte),
    .o_tlp(tlp), .o_tlp_id(tlp_id), .o_tlp_valid(tlp_valid), .i_tlp_rdy(tlp_rdy),
    .o_dllp(dllp), .o_dllp_valid(dllp_valid), .i_dllp_rdy(dllp_rdy),
    .o_status(status), .o_status_valid(status_valid), .i_status_ack(st_ack),
    .i_clr_cnt(clr), .o_crc_err_cnt(crc_cnt), .o_frm_err_cnt(frm_cnt), .o_ovf_cnt(ovf_cnt)
  );

  rx_frame_checker #(.STATUS_AW(1)) dut1 (
    .i_clk(clk), .i_arst(arst), .i_phys_k_en(k_en), .i_phys_byte(phys_byte),
    .o_tlp(tlp1), .o_tlp_id(tlp_id1), .o_tlp_valid(tlp_valid1), .i_tlp_rdy(1'b1),
    .o_dllp(dllp1), .o_dllp_valid(dllp_valid1), .i_dllp_rdy(1'b1),
    .o_status(status1), .o_status_valid(status_valid1), .i_status_ack(1'b0),
    .i_clr_cnt(1'b0), .o_crc_err_cnt(crc_cnt1), .o_frm_err_cnt(frm_cnt1), .o_ovf_cnt(ovf_cnt1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC-8, MSB first, used only to build well-formed stimulus.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  task automatic send(input logic k, input logic [7:0] b);
    @(negedge clk);
    k_en = k;
    phys_byte = b;
  endtask

  // Drives a TLP up to and including STOP; the caller clocks it in.
  task automatic send_tlp(input logic [2:0] id, input logic [31:0] pl, input logic [7:0] crc_x);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'hFF;
    b = {5'b10100, id};
    send(1'b1, Stp);
    send(1'b0, b);
    c = crc_step(c, b);
    for (int i = 3; i >= 0; i--) begin
      b = pl[8*i +: 8];
      send(1'b0, b);
      c = crc_step(c, b);
    end
    send(1'b0, c ^ crc_x);
    send(1'b1, Stop);
  endtask

  task automatic send_dllp(input logic [15:0] pl, input logic skp);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'hFF;
    send(1'b1, Sdp);
    if (skp) send(1'b1, Skp);
    for (int i = 1; i >= 0; i--) begin
      b = pl[8*i +: 8];
      send(1'b0, b);
      c = crc_step(c, b);
      if (skp) send(1'b1, Skp);
    end
    send(1'b0, c);
    if (skp) send(1'b1, Skp);
    send(1'b1, Stop);
  endtask

  task automatic pop_status();
    st_ack = 1'b1;
    send(1'b0, 8'h00);
    st_ack = 1'b0;
  endtask

  initial begin
    #2 arst = 1'b1;
    #1;
    check_eq("rst_tlp_valid", 64'(tlp_valid), 64'd0);
    check_eq("rst_tlp", 64'(tlp), 64'd0);
    check_eq("rst_dllp_valid", 64'(dllp_valid), 64'd0);
    check_eq("rst_status_valid", 64'(status_valid), 64'd0);
    check_eq("rst_cnts", {16'd0, crc_cnt, frm_cnt, ovf_cnt}, 64'd0);
    @(negedge clk);
    arst = 1'b0;

    // Good TLP, ready high: valid exactly one cycle after STOP.
    tlp_rdy = 1'b1;
    send_tlp(3'd5, 32'hDEADBEEF, 8'h00);
    check_eq("good_tlp_pre_valid", 64'(tlp_valid), 64'd0);
    send(1'b0, 8'h00);
    check_eq("good_tlp_valid", 64'(tlp_valid), 64'd1);
    check_eq("good_tlp_data", 64'(tlp), 64'hDEADBEEF);
    check_eq("good_tlp_id", 64'(tlp_id), 64'd5);
    check_eq("good_tlp_status_valid", 64'(status_valid), 64'd1);
    check_eq("good_tlp_status", 64'(status), 64'b1101);
    pop_status();
    check_eq("good_tlp_valid_drop", 64'(tlp_valid), 64'd0);
    check_eq("good_tlp_status_popped", 64'(status_valid), 64'd0);

    // Corrupted CRC.
    send_tlp(3'd5, 32'hDEADBEEF, 8'hFF);
    send(1'b0, 8'h00);
    check_eq("bad_crc_valid", 64'(tlp_valid), 64'd0);
    check_eq("bad_crc_status", 64'(status), 64'b0101);
    check_eq("bad_crc_cnt", 64'(crc_cnt), 64'd1);
    pop_status();

    clr = 1'b1;
    send(1'b0, 8'h00);
    clr = 1'b0;
    check_eq("clr_crc_cnt", 64'(crc_cnt), 64'd0);

    // DLLP with SKP between every symbol.
    dllp_rdy = 1'b1;
    send_dllp(16'hA55A, 1'b1);
    send(1'b0, 8'h00);
    check_eq("skp_dllp_valid", 64'(dllp_valid), 64'd1);
    check_eq("skp_dllp_data", 64'(dllp), 64'hA55A);
    check_eq("skp_dllp_no_status", 64'(status_valid), 64'd0);
    check_eq("skp_dllp_cnts", {16'd0, crc_cnt, frm_cnt, ovf_cnt}, 64'd0);

    // Truncated TLP resynchronised by START_DLLP.
    send(1'b1, Stp);
    send(1'b0, 8'h02);
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    send_dllp(16'h1234, 1'b0);
    send(1'b0, 8'h00);
    check_eq("resync_frm_cnt", 64'(frm_cnt), 64'd1);
    check_eq("resync_dllp_valid", 64'(dllp_valid), 64'd1);
    check_eq("resync_dllp_data", 64'(dllp), 64'h1234);
    check_eq("resync_no_status", 64'(status_valid), 64'd0);

    // Data byte where STOP is expected.
    send(1'b1, Stp);
    for (int i = 0; i < 6; i++) send(1'b0, 8'h3C);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    check_eq("bad_stop_frm_cnt", 64'(frm_cnt), 64'd2);
    check_eq("bad_stop_no_status", 64'(status_valid), 64'd0);
    check_eq("bad_stop_no_tlp", 64'(tlp_valid), 64'd0);

    // Backpressure: fresh start so the 2-deep instance sees only these three TLPs.
    @(negedge clk);
    arst = 1'b1;
    #2 arst = 1'b0;
    tlp_rdy = 1'b0;
    send_tlp(3'd1, 32'h11111111, 8'h00);
    send_tlp(3'd2, 32'h22222222, 8'h00);
    send_tlp(3'd3, 32'h33333333, 8'h00);
    send(1'b0, 8'h00);
    check_eq("bp_tlp_held", 64'(tlp), 64'h11111111);
    check_eq("bp_tlp_id_held", 64'(tlp_id), 64'd1);
    check_eq("bp_tlp_valid", 64'(tlp_valid), 64'd1);
    check_eq("bp_ovf_cnt", 64'(ovf_cnt), 64'd2);
    check_eq("bp_status0", {59'd0, status_valid, status}, 64'b11001);
    pop_status();
    check_eq("bp_status1", {59'd0, status_valid, status}, 64'b10010);
    pop_status();
    check_eq("bp_status2", {59'd0, status_valid, status}, 64'b10011);
    pop_status();
    check_eq("bp_status_empty", 64'(status_valid), 64'd0);
    check_eq("fifo2_ovf_cnt", 64'(ovf_cnt1), 64'd1);
    check_eq("fifo2_head", {59'd0, status_valid1, status1}, 64'b11001);
    check_eq("fifo2_tlp_last", 64'(tlp1), 64'h33333333);

    // Reset in the middle of a TLP payload.
    send(1'b1, Stp);
    send(1'b0, 8'h04);
    send(1'b0, 8'hAA);
    #2 arst = 1'b1;
    #1;
    check_eq("mid_rst_tlp_valid", 64'(tlp_valid), 64'd0);
    check_eq("mid_rst_tlp", {29'd0, tlp_id, tlp}, 64'd0);
    check_eq("mid_rst_ovf", 64'(ovf_cnt), 64'd0);
    check_eq("mid_rst_status", 64'(status_valid), 64'd0);
    check_eq("mid_rst_fifo2", {47'd0, status_valid1, ovf_cnt1}, 64'd0);
    #2 arst = 1'b0;
    send(1'b0, 8'hBB);
    send(1'b0, 8'hCC);
    tlp_rdy = 1'b1;
    send_tlp(3'd6, 32'hCAFEF00D, 8'h00);
    send(1'b0, 8'h00);
    check_eq("post_rst_tlp_valid", 64'(tlp_valid), 64'd1);
    check_eq("post_rst_tlp", 64'(tlp), 64'hCAFEF00D);
    check_eq("post_rst_tlp_id", 64'(tlp_id), 64'd6);
    check_eq("post_rst_status", 64'(status), 64'b1110);
    check_eq("post_rst_cnts", {16'd0, crc_cnt, frm_cnt, ovf_cnt}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
